// File: rtl/rram_cell_driver.sv
// rram_cell_driver: clocked sequencer driving the word lines and bit-line
// control terminals of an RRAM synapse row.
//
// Optional build macro: PROG_VERIFY_EN -- when defined, every PROGRAM runs a
// read window after its hold phase (READ_CYC extra cycles) before completing.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid         command request
//   cmd_ready         high only while idle
//   cmd_op            00 RESET, 01 PROGRAM, 10 READ, 11 BACK
//   cmd_row           target row
//   cmd_weight        set-pulse length in cycles (PROGRAM only)
//   wl                persistent per-row word-line levels
//   bl_set            drive bit line to set level
//   bl_back           drive bit line to back-operation level
//   dback             back-operation enable to cells
//   rd_strobe         one-cycle sample strobe for the analog output
//   done              one-cycle command completion
//   err               one-cycle: READ/BACK addressed a row whose wl is low
module rram_cell_driver #(
  parameter int unsigned N_ROWS    = 4,
  parameter int unsigned W_BITS    = 8,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned READ_CYC  = 3,
  parameter int unsigned BACK_CYC  = 4,
  parameter int unsigned RST_CYC   = 2,
  localparam int unsigned ROW_W    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ROW_W-1:0]  cmd_row,
  input  logic [W_BITS-1:0] cmd_weight,
  output logic [N_ROWS-1:0] wl,
  output logic              bl_set,
  output logic              bl_back,
  output logic              dback,
  output logic              rd_strobe,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = (W_BITS > 8) ? W_BITS : 8;

  localparam logic [1:0] OP_RESET   = 2'b00;
  localparam logic [1:0] OP_PROGRAM = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_BACK    = 2'b11;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] PULSE  = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] RDWIN  = 3'd4;
  localparam logic [2:0] RSTWIN = 3'd5;
  localparam logic [2:0] FIN    = 3'd6;

  logic [2:0]        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [CNT_W-1:0]  wgt_q, wgt_n;
  logic [1:0]        op_q, op_n;
  logic              err_q, err_n;
  logic [N_ROWS-1:0] wl_n;
  logic [CNT_W-1:0]  pulse_len;
  logic              accept;

  assign accept = cmd_valid & cmd_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // Latched command context and phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wgt_q <= '0;
      op_q  <= OP_RESET;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      wgt_q <= wgt_n;
      op_q  <= op_n;
      err_q <= err_n;
    end
  end

  // Next-state, counter and word-line update
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    wgt_n     = wgt_q;
    op_n      = op_q;
    err_n     = err_q;
    wl_n      = wl;
    pulse_len = (op_q == OP_PROGRAM) ? wgt_q : CNT_W'(BACK_CYC);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_n  = cmd_op;
          wgt_n = CNT_W'(cmd_weight);
          err_n = 1'b0;
          cnt_n = '0;
          unique case (cmd_op)
            OP_RESET: begin
              wl_n[cmd_row] = 1'b0;
              state_n       = RSTWIN;
            end
            OP_PROGRAM: begin
              wl_n[cmd_row] = 1'b1;
              state_n       = SETUP;
            end
            OP_READ: begin
              // Reading an unselected row would see no cell; flag it instead
              if (!wl[cmd_row]) begin
                err_n   = 1'b1;
                state_n = FIN;
              end else begin
                state_n = RDWIN;
              end
            end
            default: begin
              if (!wl[cmd_row]) begin
                err_n   = 1'b1;
                state_n = FIN;
              end else begin
                state_n = SETUP;
              end
            end
          endcase
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          cnt_n   = '0;
          // A zero-length set pulse skips the bit-line phase entirely
          state_n = (pulse_len == '0) ? HOLD : PULSE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == pulse_len - CNT_W'(1)) begin
          cnt_n   = '0;
          state_n = HOLD;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          cnt_n = '0;
`ifdef PROG_VERIFY_EN
          state_n = (op_q == OP_PROGRAM) ? RDWIN : FIN;
`else
          state_n = FIN;
`endif
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      RDWIN: begin
        if (cnt_q == CNT_W'(READ_CYC - 1)) begin
          cnt_n   = '0;
          state_n = FIN;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      RSTWIN: begin
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          cnt_n   = '0;
          state_n = FIN;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs: bit-line drives track the next state so they align
  // with the phase; strobe/done/err are issued the cycle after their phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      wl        <= '0;
      bl_set    <= 1'b0;
      bl_back   <= 1'b0;
      dback     <= 1'b0;
      rd_strobe <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cmd_ready <= (state_n == IDLE);
      wl        <= wl_n;
      bl_set    <= (state_n == PULSE) && (op_n == OP_PROGRAM);
      bl_back   <= (state_n == PULSE) && (op_n == OP_BACK);
      dback     <= (op_n == OP_BACK) && (state_n inside {SETUP, PULSE, HOLD});
      rd_strobe <= (state_q == RDWIN) && (cnt_q == CNT_W'(READ_CYC - 1));
      done      <= (state_q == FIN);
      err       <= (state_q == FIN) && err_q;
    end
  end

endmodule

// File: tb/tb_rram_cell_driver.sv
// Self-checking bench for rram_cell_driver: per-command expectations are
// pushed to a queue when the command is issued and popped on completion.
module tb_rram_cell_driver;

  localparam logic [1:0] OP_RESET   = 2'b00;
  localparam logic [1:0] OP_PROGRAM = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_BACK    = 2'b11;
  localparam logic [15:0] NONE      = 16'hFFFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_row;
  logic [7:0] cmd_weight;
  logic [3:0] wl;
  logic       bl_set, bl_back, dback, rd_strobe, done, err;

  typedef struct packed {
    logic [15:0] done_cyc;
    logic        err;
    logic [15:0] strobe_cyc;
    logic [15:0] set_cnt;
    logic [15:0] set_first;
    logic [15:0] back_cnt;
    logic [15:0] back_first;
    logic [15:0] dback_cnt;
    logic [3:0]  wl_first;
    logic [3:0]  wl_after;
    logic [15:0] viol;
  } obs_t;

  obs_t exp_q[$];
  logic [3:0] wl_m;
  int vectors = 0;
  int miscompares = 0;

  rram_cell_driver dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_weight(cmd_weight),
    .wl(wl), .bl_set(bl_set), .bl_back(bl_back), .dback(dback),
    .rd_strobe(rd_strobe), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: expected observation for one command, cycle k counted
  // from the accept edge (k=0 is the state just after that edge).
  function automatic obs_t predict(input logic [1:0] op, input logic [1:0] row, input int w);
    obs_t e;
    e = '0;
    e.done_cyc   = NONE;
    e.strobe_cyc = NONE;
    e.set_first  = NONE;
    e.back_first = NONE;
    case (op)
      OP_RESET: begin
        wl_m[row]  = 1'b0;
        e.done_cyc = 16'd3;
      end
      OP_PROGRAM: begin
        wl_m[row] = 1'b1;
        e.set_cnt = 16'(w);
        if (w > 0) e.set_first = 16'd2;
`ifdef PROG_VERIFY_EN
        e.strobe_cyc = 16'(w + 7);
        e.done_cyc   = 16'(w + 8);
`else
        e.done_cyc   = 16'(w + 5);
`endif
      end
      OP_READ: begin
        if (!wl_m[row]) begin
          e.err = 1'b1; e.done_cyc = 16'd1;
        end else begin
          e.strobe_cyc = 16'd3; e.done_cyc = 16'd4;
        end
      end
      default: begin
        if (!wl_m[row]) begin
          e.err = 1'b1; e.done_cyc = 16'd1;
        end else begin
          e.back_first = 16'd2; e.back_cnt = 16'd4;
          e.dback_cnt  = 16'd8; e.done_cyc = 16'd9;
        end
      end
    endcase
    e.wl_first = wl_m;
    e.wl_after = wl_m;
    return e;
  endfunction

  // Issue one command and record what the DUT did until done (no checking here)
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] row, input int w, output obs_t o);
    o = '0;
    o.done_cyc   = NONE;
    o.strobe_cyc = NONE;
    o.set_first  = NONE;
    o.back_first = NONE;
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_row    = row;
    cmd_weight = 8'(w);
    @(posedge clk);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0) begin
        cmd_valid = 1'b0;
        o.wl_first = wl;
      end
      if (bl_set) begin
        o.set_cnt++;
        if (o.set_first == NONE) o.set_first = 16'(k);
      end
      if (bl_back) begin
        o.back_cnt++;
        if (o.back_first == NONE) o.back_first = 16'(k);
      end
      if (dback) o.dback_cnt++;
      if ((bl_set && bl_back) || ((bl_set || bl_back) && !wl[row])) o.viol++;
      if (err && !done) o.viol++;
      if (rd_strobe) begin
        if (o.strobe_cyc != NONE) o.viol++;
        o.strobe_cyc = 16'(k);
      end
      if (done) begin
        o.done_cyc = 16'(k);
        o.err      = err;
        o.wl_after = wl;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_row = '0; cmd_weight = '0;
    wl_m = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cmd_ready, wl, bl_set, bl_back, dback, rd_strobe, done, err} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected %b",
               {cmd_ready, wl, bl_set, bl_back, dback, rd_strobe, done, err}, 10'b0);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_clk: got %b expected 0", cmd_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_clk: got %b expected 1", cmd_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_program();
    obs_t o, e;
    exp_q.push_back(predict(OP_PROGRAM, 2'd1, 5));
    run_cmd(OP_PROGRAM, 2'd1, 5, o);
    e = exp_q.pop_front();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL program_row1_w5: got %h expected %h", o, e);
    end
  endtask

  task automatic test_program_zero();
    obs_t o, e;
    exp_q.push_back(predict(OP_PROGRAM, 2'd2, 0));
    run_cmd(OP_PROGRAM, 2'd2, 0, o);
    e = exp_q.pop_front();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL program_row2_w0: got %h expected %h", o, e);
    end
  endtask

  task automatic test_read();
    obs_t o, e;
    exp_q.push_back(predict(OP_READ, 2'd1, 0));
    run_cmd(OP_READ, 2'd1, 0, o);
    e = exp_q.pop_front();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL read_row1: got %h expected %h", o, e);
    end
  endtask

  task automatic test_back();
    obs_t o, e;
    logic [1:0] ops[3] = '{OP_BACK, OP_PROGRAM, OP_BACK};
    int         ws[3]  = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(predict(ops[i], 2'd3, ws[i]));
      run_cmd(ops[i], 2'd3, ws[i], o);
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL back_seq_%0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_cmd();
    obs_t o, e;
    logic [1:0] ops[2] = '{OP_RESET, OP_READ};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(predict(ops[i], 2'd1, 0));
      run_cmd(ops[i], 2'd1, 0, o);
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_cmd_seq_%0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_verify();
    obs_t o, e;
    exp_q.push_back(predict(OP_PROGRAM, 2'd0, 3));
    run_cmd(OP_PROGRAM, 2'd0, 3, o);
    e = exp_q.pop_front();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL program_row0_w3: got %h expected %h", o, e);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    logic [1:0] op, row;
    int w;
    for (int i = 0; i < 16; i++) begin
      op  = 2'($urandom_range(0, 3));
      row = 2'($urandom_range(0, 3));
      w   = $urandom_range(0, 6);
      exp_q.push_back(predict(op, row, w));
      run_cmd(op, row, w, o);
      e = exp_q.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL b2b_%0d op=%0d row=%0d w=%0d: got %h expected %h", i, op, row, w, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    int done_seen;
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_PROGRAM; cmd_row = 2'd0; cmd_weight = 8'd200;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({bl_set, wl[0]} !== 2'b11) begin
      miscompares++;
      $display("FAIL pulse_before_reset: got %b expected 11", {bl_set, wl[0]});
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({wl, bl_set, bl_back, dback, done, cmd_ready} !== 9'b0) begin
      miscompares++;
      $display("FAIL async_drop: got %b expected %b", {wl, bl_set, bl_back, dback, done, cmd_ready}, 9'b0);
    end
    wl_m = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (done || bl_set) done_seen++;
    end
    vectors++;
    if ({done_seen, cmd_ready, wl} !== {32'd0, 1'b1, 4'b0}) begin
      miscompares++;
      $display("FAIL discarded_cmd: got done/bl=%0d ready=%b wl=%b expected 0 1 0000",
               done_seen, cmd_ready, wl);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_program_zero();
    test_read();
    test_back();
    test_reset_cmd();
    test_verify();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
